// File: rtl/mdu_ctrl.sv
// mdu_ctrl: accepts one RV32M op, runs it through the iterative mdu (or resolves it locally), hands result to writeback.
// Optional one-entry result reuse cache is built when MDU_REUSE_EN is defined.
module mdu_ctrl #(
    parameter int unsigned WATCHDOG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        mdu_start,
    output logic [2:0]  mdu_funct3,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mdu_busy,
    input  logic        mdu_done,
    input  logic [63:0] mdu_product,
    input  logic [31:0] mdu_quotient,
    input  logic [31:0] mdu_remainder,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam int unsigned    CW       = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0]  WD_LIMIT = CW'(WATCHDOG_CYCLES);

    logic [2:0]    state_q,  state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   a_q,      a_d;
    logic [31:0]   b_q,      b_d;
    logic [4:0]    rd_q,     rd_d;
    logic [31:0]   data_q,   data_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q,    err_d;

    logic          req_fire;
    logic          wd_hit;
    logic          cache_hit;
    logic [31:0]   cache_data;
    logic          busy_unused;

    assign busy_unused = mdu_busy;

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic div_zero;
        logic overflow;
        div_zero = f[2] && (b == 32'd0);
        overflow = (f == 3'd4 || f == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return div_zero || overflow;
    endfunction

    // Only called when is_special holds: b==0 means divide by zero, otherwise signed overflow.
    function automatic logic [31:0] special_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = f[1] ? a : 32'hFFFF_FFFF;
        end else begin
            r = f[1] ? 32'd0 : 32'h8000_0000;
        end
        return r;
    endfunction

    function automatic logic [31:0] select_result(input logic [2:0] f, input logic [63:0] prod,
                                                  input logic [31:0] quo, input logic [31:0] rem);
        logic [31:0] r;
        if (f == 3'd0) begin
            r = prod[31:0];
        end else if (!f[2]) begin
            r = prod[63:32];
        end else if (f[1]) begin
            r = rem;
        end else begin
            r = quo;
        end
        return r;
    endfunction

    assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign req_fire   = req_valid && req_ready;
    assign mdu_start  = (state_q == S_LAUNCH);
    assign mdu_funct3 = funct3_q;
    assign mdu_a      = a_q;
    assign mdu_b      = b_q;
    assign wb_valid   = (state_q == S_WB);
    assign wb_rd      = rd_q;
    assign wb_data    = data_q;
    assign stall      = (state_q != S_IDLE);
    assign err        = err_q;

    // Counter holds cycles since mdu_start, so expiry lands err exactly WATCHDOG_CYCLES after the launch.
    assign wd_hit = (wd_cnt_q == WD_LIMIT - CW'(1));

`ifdef MDU_REUSE_EN
    logic          c_valid_q,  c_valid_d;
    logic [2:0]    c_funct3_q, c_funct3_d;
    logic [31:0]   c_a_q,      c_a_d;
    logic [31:0]   c_b_q,      c_b_d;
    logic [63:0]   c_prod_q,   c_prod_d;
    logic [31:0]   c_quo_q,    c_quo_d;
    logic [31:0]   c_rem_q,    c_rem_d;
    logic          fill_en;
    logic          compat;

    assign fill_en = (state_q == S_WAIT) && mdu_done && !flush;

    // Low product word is signedness-independent; signed and unsigned divides each share one entry.
    always_comb begin
        compat = 1'b0;
        case (req_funct3)
            3'd0:                compat = !c_funct3_q[2];
            3'd1, 3'd2, 3'd3:    compat = (c_funct3_q == req_funct3);
            default:             compat = c_funct3_q[2] && (c_funct3_q[0] == req_funct3[0]);
        endcase
    end

    assign cache_hit  = c_valid_q && compat && (c_a_q == req_rs1) && (c_b_q == req_rs2);
    assign cache_data = select_result(req_funct3, c_prod_q, c_quo_q, c_rem_q);

    always_comb begin
        c_valid_d  = c_valid_q;
        c_funct3_d = c_funct3_q;
        c_a_d      = c_a_q;
        c_b_d      = c_b_q;
        c_prod_d   = c_prod_q;
        c_quo_d    = c_quo_q;
        c_rem_d    = c_rem_q;
        if (fill_en) begin
            c_valid_d  = 1'b1;
            c_funct3_d = funct3_q;
            c_a_d      = a_q;
            c_b_d      = b_q;
            c_prod_d   = mdu_product;
            c_quo_d    = mdu_quotient;
            c_rem_d    = mdu_remainder;
        end
        if (flush || err_d) begin
            c_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid_q  <= 1'b0;
            c_funct3_q <= '0;
            c_a_q      <= '0;
            c_b_q      <= '0;
            c_prod_q   <= '0;
            c_quo_q    <= '0;
            c_rem_q    <= '0;
        end else begin
            c_valid_q  <= c_valid_d;
            c_funct3_q <= c_funct3_d;
            c_a_q      <= c_a_d;
            c_b_q      <= c_b_d;
            c_prod_q   <= c_prod_d;
            c_quo_q    <= c_quo_d;
            c_rem_q    <= c_rem_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 32'd0;
`endif

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        data_d   = data_q;
        wd_cnt_d = wd_cnt_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    funct3_d = req_funct3;
                    a_d      = req_rs1;
                    b_d      = req_rs2;
                    rd_d     = req_rd;
                    if (is_special(req_funct3, req_rs1, req_rs2)) begin
                        data_d  = special_result(req_funct3, req_rs1, req_rs2);
                        state_d = S_WB;
                    end else if (cache_hit) begin
                        data_d  = cache_data;
                        state_d = S_WB;
                    end else begin
                        wd_cnt_d = '0;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                wd_cnt_d = CW'(1);
                state_d  = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with flush is simply discarded; nothing left to drain.
                if (mdu_done) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = select_result(funct3_q, mdu_product, mdu_quotient, mdu_remainder);
                        state_d = S_WB;
                    end
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                    if (flush) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (mdu_done) begin
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            S_WB: begin
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: behavioural mdu responder, RV32M reference model, decoupled result monitor.
module tb_mdu_ctrl;

    localparam int W = 48;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        mdu_start;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_a, mdu_b;
    logic        mdu_busy, mdu_done;
    logic [63:0] mdu_product;
    logic [31:0] mdu_quotient, mdu_remainder;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, err;

    always #5 clk = ~clk;

    mdu_ctrl #(.WATCHDOG_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .mdu_start(mdu_start), .mdu_funct3(mdu_funct3), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_product(mdu_product),
        .mdu_quotient(mdu_quotient), .mdu_remainder(mdu_remainder),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .err(err)
    );

    typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
    exp_t sb_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0, start_cyc = 0, done_cyc = 0, wbv_cyc = 0, err_cyc = 0;
    int start_count = 0, err_count = 0, wb_rise_count = 0;
    int mdu_lat_fix = 0;
    bit mdu_mute = 1'b0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32M architectural result, including the divide-by-zero and overflow rules.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        full;
        logic signed [31:0] as_, bs_;
        as_ = a;
        bs_ = b;
        case (f)
            3'd0: return 32'(a * b);
            3'd1: begin full = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})); return full[63:32]; end
            3'd2: begin full = 64'($signed({{32{a[31]}}, a}) * $signed({32'd0, b})); return full[63:32]; end
            3'd3: begin full = {32'd0, a} * {32'd0, b}; return full[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(as_ / bs_);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(as_ % bs_);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural iterative unit: answers each start after a latency; division by zero yields junk.
    initial begin : mdu_model
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [63:0] p;
        longint      sa, sb, ua, ub;
        int          lat;
        mdu_done = 0; mdu_busy = 0; mdu_product = 0; mdu_quotient = 0; mdu_remainder = 0;
        forever begin
            @(negedge clk);
            if (mdu_start === 1'b1) begin
                start_count++;
                start_cyc = cyc;
                f = mdu_funct3; a = mdu_a; b = mdu_b;
                if (!mdu_mute) begin
                    lat = (mdu_lat_fix > 0) ? mdu_lat_fix : int'($urandom_range(1, 8));
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
                    case (f)
                        3'd0, 3'd1: p = 64'(sa * sb);
                        3'd2:       p = 64'(sa * ub);
                        default:    p = 64'(ua * ub);
                    endcase
                    mdu_busy = 1;
                    repeat (lat) @(posedge clk);
                    #1;
                    mdu_product = p;
                    if (b == 0) begin
                        mdu_quotient = 32'hDEAD_BEEF; mdu_remainder = 32'hDEAD_BEEF;
                    end else if (f[0]) begin
                        mdu_quotient = 32'(ua / ub); mdu_remainder = 32'(ua % ub);
                    end else begin
                        mdu_quotient = 32'(sa / sb); mdu_remainder = 32'(sa % sb);
                    end
                    mdu_done = 1;
                    done_cyc = cyc;
                    @(posedge clk);
                    #1;
                    mdu_done = 0;
                    mdu_busy = 0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic wbv_prev;
        wbv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_valid && !wbv_prev) begin
                    wbv_cyc = cyc;
                    wb_rise_count++;
                end
                if (err) begin
                    err_count++;
                    err_cyc = cyc;
                end
                if (wb_valid && wb_ready && !flush) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_wb: got rd %0d data %0h expected no result", wb_rd, wb_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("wb_rd", 64'(wb_rd), 64'(e.rd));
                        check("wb_data", 64'(wb_data), 64'(e.data));
                    end
                end
            end
            wbv_prev = wb_valid;
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) wb_ready = 1'b1;
            else if (rdy_mode == 1) wb_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expect_wb);
        int k;
        @(posedge clk);
        #1;
        req_valid = 1; req_funct3 = f; req_rs1 = a; req_rs2 = b; req_rd = rd;
        k = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            k++;
            if (k > 200) begin
                n_checks++; n_fail++;
                $display("FAIL req_accept_timeout: got no req_ready expected accept within 200 cycles");
                break;
            end
        end
        acc_cyc = cyc;
        if (expect_wb) sb_q.push_back(exp_t'{rd, ref_result(f, a, b)});
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (!stall && !wb_valid && sb_q.size() == 0) break;
            k++;
            if (k > 300) begin
                n_checks++; n_fail++;
                $display("FAIL idle_timeout: got stall %0b pending %0d expected idle", stall, sb_q.size());
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : stimulus
        int s0, e0, r0, k;
        logic [2:0]  f;
        logic [31:0] a, b;
        rst = 1; flush = 0; req_valid = 0; req_funct3 = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0; wb_ready = 1;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_wb_valid", 64'(wb_valid), 64'd0);
        check("reset_mdu_start", 64'(mdu_start), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_wb_data", 64'(wb_data), 64'd0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("post_reset_req_ready", 64'(req_ready), 64'd1);

        // MULH then MUL on the same operands
        s0 = start_count;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd5, 1);
        wait_idle();
        check("mulh_start_pulses", 64'(start_count - s0), 64'd1);
        check("mulh_start_cycle", 64'(start_cyc), 64'(acc_cyc + 1));
        check("mulh_wb_cycle", 64'(wbv_cyc), 64'(done_cyc + 1));
        s0 = start_count;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 5'd6, 1);
        wait_idle();
`ifdef MDU_REUSE_EN
        check("mul_reuse_no_start", 64'(start_count - s0), 64'd0);
        check("mul_reuse_wb_cycle", 64'(wbv_cyc), 64'(acc_cyc + 1));
`else
        check("mul_start_pulses", 64'(start_count - s0), 64'd1);
`endif

        // signed overflow and divide by zero resolve locally
        s0 = start_count;
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1);
        wait_idle();
        check("div_ovf_wb_cycle", 64'(wbv_cyc), 64'(acc_cyc + 1));
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd9, 1);
        issue(3'd5, 32'd5, 32'd0, 5'd0, 1);
        wait_idle();
        check("special_no_start", 64'(start_count - s0), 64'd0);

        // flush five cycles after mdu_start
        mdu_lat_fix = 12;
        r0 = wb_rise_count;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 0);
        repeat (5) @(posedge clk);
        #1; flush = 1;
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        check("drain_stall", 64'(stall), 64'd1);
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        check("drain_ready_cycle", 64'(cyc), 64'(done_cyc + 1));
        check("drain_no_wb", 64'(wb_rise_count - r0), 64'd0);
        mdu_lat_fix = 0;

        // flush beats wb_ready in WB
        rdy_mode = 2; wb_ready = 0;
        issue(3'd5, 32'd9, 32'd0, 5'd3, 0);
        flush = 1; wb_ready = 1;
        @(negedge clk);
        check("wb_flush_valid_before", 64'(wb_valid), 64'd1);
        @(posedge clk); #1; flush = 0; wb_ready = 0;
        @(negedge clk);
        check("wb_flush_dropped", 64'(wb_valid), 64'd0);
        check("wb_flush_idle", 64'(stall), 64'd0);

        // REMU held by wb_ready low for three cycles
        issue(3'd7, 32'd100, 32'd7, 5'd12, 1);
        k = 0;
        while (!wb_valid && k < 100) begin @(negedge clk); k++; end
        for (int i = 0; i < 3; i++) begin
            check("remu_hold_valid", 64'(wb_valid), 64'd1);
            check("remu_hold_data", 64'(wb_data), 64'd2);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1; wb_ready = 1;
        @(negedge clk);
        @(posedge clk); #1; rdy_mode = 0;
        @(negedge clk);
        check("remu_delivered", 64'(sb_q.size()), 64'd0);
        wait_idle();

        // watchdog: mdu never answers
        mdu_mute = 1;
        e0 = err_count; r0 = wb_rise_count;
        issue(3'd3, $urandom, $urandom, 5'd4, 0);
        repeat (W + 20) @(negedge clk);
        check("wd_err_pulses", 64'(err_count - e0), 64'd1);
        check("wd_err_cycle", 64'(err_cyc), 64'(start_cyc + W));
        check("wd_idle", 64'(stall), 64'd0);
        check("wd_no_wb", 64'(wb_rise_count - r0), 64'd0);
        mdu_mute = 0;

        // randomized traffic with operand reuse
        rdy_mode = 1;
        a = 0; b = 0;
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                a = pick_operand();
                b = pick_operand();
            end
            issue(f, a, b, 5'($urandom), 1);
        end
        wait_idle();
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_timeout
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller between the execute stage and the iterative multiply/divide unit (`mdu`). It accepts one RV32M operation per valid/ready handshake, launches `mdu` with a single-cycle `start` pulse, and waits for `done`. It then selects the architectural 32-bit result and presents it to writeback on a valid/ready handshake. It resolves the RISC-V divide-by-zero and signed-overflow cases itself, without invoking `mdu`, and handles pipeline flush while `mdu` is in flight.

## Interface
Parameters:
- `WATCHDOG_CYCLES`, default 48: maximum cycles from `mdu_start` to `mdu_done` before the operation is aborted.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the in-flight or pending operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_funct3`  in  3  funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `req_rs1`, `req_rs2`  in  32 each  operand values.
- `req_rd`  in  5  destination register.
- `mdu_start`  out  1  one-cycle launch pulse to `mdu`.
- `mdu_funct3`  out  3  registered funct3 to `mdu`.
- `mdu_a`, `mdu_b`  out  32 each  registered operands to `mdu`.
- `mdu_busy`  in  1  `mdu` busy; informational only.
- `mdu_done`  in  1  `mdu` completion pulse.
- `mdu_product`  in  64  product from `mdu`.
- `mdu_quotient`, `mdu_remainder`  in  32 each  quotient and remainder from `mdu`.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback accepts the result.
- `wb_rd`  out  5  destination register for the result.
- `wb_data`  out  32  result value.
- `stall`  out  1  high whenever state is not IDLE.
- `err`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, LAUNCH, WAIT, WB, DRAIN.
- IDLE:
  - `req_ready = !flush`.
  - On handshake, register funct3, rs1, rs2 and rd.
  - Special case (funct3 ≥ 4 and rs2 == 0, or funct3 ∈ {4,6} and rs1 == 0x80000000 and rs2 == 0xFFFFFFFF): compute the result directly and go to WB.
  - Otherwise go to LAUNCH.
- LAUNCH: `mdu_start = 1` for exactly one cycle, with `mdu_*` driven from the registered request; go to WAIT.
- WAIT:
  - On `mdu_done`, capture the selected result into `wb_data` and go to WB.
  - Result select: MUL → `product[31:0]`; MULH, MULHSU, MULHU → `product[63:32]`; DIV, DIVU → quotient; REM, REMU → remainder.
- WB:
  - `wb_valid` is held high, and `wb_rd`/`wb_data` are held stable, until `wb_ready`.
  - On `wb_ready`, go to IDLE.
- Special-case results:
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1 unmodified.
  - Signed overflow: DIV returns 0x80000000; REM returns 0.
- Flush:
  - IDLE: no request is accepted that cycle.
  - LAUNCH or WAIT: go to DRAIN. `mdu` cannot be aborted, so DRAIN waits for `mdu_done`, discards the result, then goes to IDLE.
  - DRAIN: flush has no further effect.
  - WB: drop `wb_valid` and go to IDLE. If `wb_ready` arrives in the same cycle, flush wins and the result is not delivered.
- Watchdog:
  - The counter clears on entering LAUNCH and counts in WAIT and DRAIN.
  - When it reaches `WATCHDOG_CYCLES`: pulse `err`, discard the operation, go to IDLE.
- `rd == 0` is executed and delivered normally; writeback ignores it.

## Timing
- Reset values: `req_ready = 0` during reset; all other outputs 0; state IDLE; reuse cache invalid.
- Special-case path: request accepted in cycle N; `wb_valid` high in N+1.
- `mdu` path:
  - `mdu_start` is high in N+1.
  - `wb_valid` is high in the cycle after `mdu_done` is sampled.
- Back-to-back: `req_ready` rises in the cycle after the WB handshake, so the minimum spacing between requests is 2 cycles (special case or cache hit).
- An `mdu_done` received in IDLE or WB is ignored.

## Configuration
- `MDU_REUSE_EN` defined:
  - The controller keeps a one-entry cache of the last `mdu` result: operands, funct3, product, quotient, remainder.
  - A new request hits the cache when rs1 and rs2 match and the funct3 is compatible:
    - MUL matches any cached multiply.
    - MULH, MULHSU and MULHU require an identical cached funct3.
    - DIV/REM share a cached entry, and DIVU/REMU share a cached entry.
  - A hit skips `mdu` and behaves like the special-case path.
  - The cache is invalidated on reset, flush and watchdog expiry.
  - The cache is refilled only by an `mdu_done` captured in WAIT.
- `MDU_REUSE_EN` undefined: no cache is built, and every non-special request launches `mdu`.

## Test plan
- MULH with rs1 = 0xFFFFFFFE, rs2 = 3 → exactly one `mdu_start` pulse; `wb_data` = 0xFFFFFFFF; then MUL with the same operands → 0xFFFFFFFA. With `MDU_REUSE_EN`, the MUL issues no `mdu_start`.
- DIV with rs1 = 0x80000000, rs2 = 0xFFFFFFFF → `wb_data` = 0x80000000 in N+1 with no `mdu_start`; REM with the same operands → 0.
- REM with rs1 = 0xFFFFFFF9 (-7), rs2 = 0 → `wb_data` = 0xFFFFFFF9; DIVU with rs1 = 5, rs2 = 0 → 0xFFFFFFFF.
- DIV with rs1 = 0xFFFFFFF9, rs2 = 2, and `flush` asserted 5 cycles after `mdu_start` → state goes to DRAIN, no `wb_valid`; `req_ready` returns 1 the cycle after `mdu_done`.
- REMU with rs1 = 100, rs2 = 7 while `wb_ready` is held low 3 cycles → `wb_valid` and `wb_data` = 2 are held stable; delivered on the first `wb_ready` cycle.
- `mdu_done` tied low after a MULHU request → `err` pulses exactly once, `WATCHDOG_CYCLES` cycles after `mdu_start`; state returns to IDLE with no `wb_valid`.
